// File: rtl/rr_grant_arbiter16.sv
`default_nettype none
// ============================================================================
// Module   : rr_grant_arbiter16
// Brief    : 16-requester round-robin arbiter with registered one-hot grant
//            and a hold limit that forces rotation under contention.
// Revision : 1.0 - initial release
// ============================================================================
module rr_grant_arbiter16 #(
    parameter int MAX_HOLD = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] req,
    output logic [15:0] grant,
    output logic        grant_valid
);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_t;

    localparam logic [7:0] c_max_hold = 8'(MAX_HOLD);

    state_t      r_state, w_state_nxt;
    logic [3:0]  r_ptr, w_ptr_nxt;
    logic [3:0]  r_gidx, w_gidx_nxt;
    logic [7:0]  r_hold_cnt, w_hold_nxt;
    logic [15:0] r_grant, w_grant_nxt;
    logic        r_valid, w_valid_nxt;
    logic [3:0]  w_win_idx;
    logic [3:0]  w_scan_idx;
    logic        w_release;
    logic        w_force;

    // Scan downward so the lowest offset from r_ptr is the last (winning) write.
    always_comb begin
        w_win_idx  = r_ptr;
        w_scan_idx = r_ptr;
        for (int i = 15; i >= 0; i--) begin
            w_scan_idx = r_ptr + 4'(i);
            if (req[w_scan_idx]) begin
                w_win_idx = w_scan_idx;
            end
        end
    end

    always_comb begin
        w_release = !req[r_gidx];
        w_force   = (c_max_hold != 8'd0) && (r_hold_cnt == c_max_hold) &&
                    req[r_gidx] && (|(req & ~r_grant));
    end

    always_comb begin
        w_state_nxt = r_state;
        w_ptr_nxt   = r_ptr;
        w_gidx_nxt  = r_gidx;
        w_hold_nxt  = r_hold_cnt;
        w_grant_nxt = r_grant;
        w_valid_nxt = r_valid;
        case (r_state)
            ST_IDLE: begin
                if (|req) begin
                    w_state_nxt = ST_GRANT;
                    w_gidx_nxt  = w_win_idx;
                    w_grant_nxt = 16'h0001 << w_win_idx;
                    w_valid_nxt = 1'b1;
                    w_hold_nxt  = 8'd1;
                end
            end
            ST_GRANT: begin
                if (w_release || w_force) begin
                    // Pointer moves past the old winner, leaving one idle bubble.
                    w_state_nxt = ST_IDLE;
                    w_ptr_nxt   = r_gidx + 4'd1;
                    w_grant_nxt = 16'h0000;
                    w_valid_nxt = 1'b0;
                    w_hold_nxt  = 8'd0;
                end else if ((c_max_hold != 8'd0) && (r_hold_cnt >= c_max_hold)) begin
                    w_hold_nxt = r_hold_cnt;
                end else if (r_hold_cnt != 8'hFF) begin
                    w_hold_nxt = r_hold_cnt + 8'd1;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= ST_IDLE;
            r_ptr      <= 4'd0;
            r_gidx     <= 4'd0;
            r_hold_cnt <= 8'd0;
            r_grant    <= 16'h0000;
            r_valid    <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_ptr      <= w_ptr_nxt;
            r_gidx     <= w_gidx_nxt;
            r_hold_cnt <= w_hold_nxt;
            r_grant    <= w_grant_nxt;
            r_valid    <= w_valid_nxt;
        end
    end

    assign grant       = r_grant;
    assign grant_valid = r_valid;

endmodule
`default_nettype wire
